mem_responder: RTL and testbench

Responder end of the CPU data-memory interface: accepts the core's `MemRead`/`MemWrite` requests and returns read data or commits writes after a fixed, parameterised number of wait states. It replaces the zero-latency `Data_Memory` model where the core must tolerate realistic memory timing. It holds the core through a `stall_o` output and reports misaligned or out-of-range accesses.

---
 rtl/mem_resp_pkg.sv | 21 ++
 rtl/mem_resp_array.sv | 36 +++
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the mem_responder slice.
// Holds the responder FSM state encoding, the wait-counter width and the
// bit positions of the error causes evaluated at request capture.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wait counter must hold WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

  // Bit positions inside the error-cause vector.
  localparam int MISALIGN = 0;
  localparam int RANGE    = 1;
  localparam int CONFLICT = 2;
  localparam int N_ERR    = 3;

endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: word RAM behind the responder, synchronous write, combinational read.
// Latency: write lands on the clock edge with we_i=1; read data follows idx_i combinationally.
// Backpressure: none; the owning FSM decides when we_i fires.
// Ports: clk_i clock, we_i write enable, idx_i word index (shared read/write),
//        wdata_i write data, be_i byte enables (only with MEM_RESP_BYTE_EN), rdata_o read data.
// Contents are never reset.
module mem_resp_array #(
  parameter int DEPTH_WORDS = 128
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
  input  logic [31:0]                    wdata_i,
`ifdef MEM_RESP_BYTE_EN
  input  logic [3:0]                     be_i,
`endif
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
`ifdef MEM_RESP_BYTE_EN
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
`else
      mem_q[idx_i] <= wdata_i;
`endif
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: responder side of the CPU data-memory port with fixed wait states.
// Latency: request captured at edge N, ready_o high in cycle N+WAIT_CYCLES+1.
// Backpressure: stall_o holds the core while a request is pending (IDLE+req, WAIT).
// Ports: clk_i/rst_i (sync, active-high), MemRead_i/MemWrite_i requests, addr_i byte
//        address, data_i write data, be_i byte enables (MEM_RESP_BYTE_EN builds only),
//        data_o read data (0 unless a good read responds), ready_o response strobe,
//        err_o error qualifier for ready_o, stall_o core hold.
// Optional feature macro: MEM_RESP_BYTE_EN (byte-lane writes).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
`ifdef MEM_RESP_BYTE_EN
  input  logic [3:0]  be_i,
`endif
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        data_q, data_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;
`ifdef MEM_RESP_BYTE_EN
  logic [3:0]         be_q, be_d;
`endif

  logic               req;
  logic [N_ERR-1:0]   cause;
  logic               mem_we;
  logic [31:0]        mem_rdata;

  assign req = MemRead_i | MemWrite_i;

  always_comb begin
    cause           = '0;
    cause[MISALIGN] = |addr_i[1:0];
    // Whole 30-bit word index is compared so aliasing high bits count as out of range.
    cause[RANGE]    = {2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS);
    cause[CONFLICT] = MemRead_i & MemWrite_i;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q <= CNT_W'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches and wait counter; inputs are only looked at in IDLE.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    data_d = data_q;
    wr_d   = wr_q;
    err_d  = err_q;
`ifdef MEM_RESP_BYTE_EN
    be_d   = be_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d  = CNT_W'(WAIT_CYCLES);
          idx_d  = addr_i[IDX_W+1:2];
          data_d = data_i;
          wr_d   = MemWrite_i;
          err_d  = |cause;
`ifdef MEM_RESP_BYTE_EN
          be_d   = be_i;
`endif
        end
      end
      WAIT:    cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
`ifdef MEM_RESP_BYTE_EN
      be_q   <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      wr_q   <= wr_d;
      err_q  <= err_d;
`ifdef MEM_RESP_BYTE_EN
      be_q   <= be_d;
`endif
    end
  end

  // Output logic
  always_comb begin
    stall_o = 1'b0;
    ready_o = 1'b0;
    err_o   = 1'b0;
    data_o  = '0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: stall_o = req;
      WAIT: stall_o = 1'b1;
      RESP: begin
        ready_o = 1'b1;
        err_o   = err_q;
        data_o  = (!wr_q && !err_q) ? mem_rdata : '0;
        // A reset landing on the RESP edge discards the pending write.
        mem_we  = wr_q & ~err_q & ~rst_i;
      end
      default: ;
    endcase
  end

  mem_resp_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .idx_i  (idx_q),
    .wdata_i(data_q),
`ifdef MEM_RESP_BYTE_EN
    .be_i   (be_q),
`endif
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0, sel = 1'b0;
  logic [31:0] addr = '0, data = '0;
  logic [3:0]  be = 4'hF;

  logic [31:0] dout2, dout0;
  logic        ready2, ready0, err2, err0, stall2, stall0;
  logic [31:0] dout;
  logic        ready, errq, stall;

  int checks = 0;
  int errors = 0;

  // Reference memories: [0] for the 2-wait-state DUT, [1] for the 0-wait-state DUT.
  logic [31:0] model [2][128];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd & ~sel), .MemWrite_i(wr & ~sel),
    .addr_i(addr), .data_i(data),
`ifdef MEM_RESP_BYTE_EN
    .be_i(be),
`endif
    .data_o(dout2), .ready_o(ready2), .err_o(err2), .stall_o(stall2));

  mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd & sel), .MemWrite_i(wr & sel),
    .addr_i(addr), .data_i(data),
`ifdef MEM_RESP_BYTE_EN
    .be_i(be),
`endif
    .data_o(dout0), .ready_o(ready0), .err_o(err0), .stall_o(stall0));

  assign dout  = sel ? dout0  : dout2;
  assign ready = sel ? ready0 : ready2;
  assign errq  = sel ? err0   : err2;
  assign stall = sel ? stall0 : stall2;

  function automatic int exp_wait();
    return sel ? 0 : 2;
  endfunction

  // Behavioural reference: decides the outcome of one access from its inputs alone.
  function automatic void model_access(input int s, input bit r, input bit w,
                                       input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] b,
                                       output bit e, output logic [31:0] q);
    logic [3:0] beff;
    int unsigned idx;
    idx = a >> 2;
`ifdef MEM_RESP_BYTE_EN
    beff = b;
`else
    beff = 4'hF | b;
`endif
    e = (a % 4 != 0) || (idx >= 128) || (r && w);
    q = '0;
    if (!e) begin
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (beff[k]) model[s][idx][8*k +: 8] = d[8*k +: 8];
      end else begin
        q = model[s][idx];
      end
    end
  endfunction

  // Drives one request starting at a negedge and follows it to its response.
  task automatic drive_access(input bit r, input bit w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] b, input bit chaos,
                             output logic [31:0] rdat, output logic rerr, output int stalls,
                             output int lat, output bit got, output logic stall_at_rdy);
    rd = r; wr = w; addr = a; data = d; be = b;
    stalls = 0; lat = 0; got = 0; rdat = '0; rerr = 1'b0; stall_at_rdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ready) begin
        got = 1; lat = c; rdat = dout; rerr = errq; stall_at_rdy = stall;
        break;
      end
      if (stall) stalls++;
      @(negedge clk);
      if (chaos) begin addr = $urandom; data = $urandom; be = 4'($urandom); end
    end
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL reset ready: got %b want 0", ready2); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err2); end
    checks++; if (dout2 !== 32'h0) begin errors++; $display("FAIL reset data: got %h want 0", dout2); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (stall2 !== 1'b0) begin errors++; $display("FAIL idle stall: got %b want 0", stall2); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL idle ready0: got %b want 0", ready0); end
    @(negedge clk);
  endtask

  task automatic test_init();
    logic [31:0] q, rdat; bit e, got; logic rerr, sr; int st, lat;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 128; i++) begin
        logic [31:0] d;
        d = $urandom;
        model_access(s, 0, 1, 32'(i) << 2, d, 4'hF, e, q);
        drive_access(0, 1, 32'(i) << 2, d, 4'hF, 0, rdat, rerr, st, lat, got, sr);
        checks++; if (!got || rerr !== 1'b0) begin errors++; $display("FAIL init write %0d/%0d: got ready=%b err=%b want ready=1 err=0", s, i, got, rerr); end
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] q, rdat; bit e, got; logic rerr, sr; int st, lat;
    sel = 1'b0;
    model_access(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, e, q);
    drive_access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rdat, rerr, st, lat, got, sr);
    checks++; if (st !== 3) begin errors++; $display("FAIL wr stall cycles: got %0d want 3", st); end
    checks++; if (!got || lat !== 3) begin errors++; $display("FAIL wr latency: got %0d (ready=%b) want 3", lat, got); end
    checks++; if (sr !== 1'b0) begin errors++; $display("FAIL wr stall in resp: got %b want 0", sr); end
    drive_access(1, 0, 32'h10, 32'h0, 4'hF, 0, rdat, rerr, st, lat, got, sr);
    checks++; if (rdat !== 32'hDEADBEEF) begin errors++; $display("FAIL rd data: got %h want deadbeef", rdat); end
    checks++; if (!got || rerr !== 1'b0) begin errors++; $display("FAIL rd err: got %b (ready=%b) want 0", rerr, got); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd latency: got %0d want 3", lat); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] q, rdat; bit e, got; logic rerr, sr; int st, lat;
    sel = 1'b1;
    model_access(1, 1, 0, 32'h0, 32'h0, 4'hF, e, q);
    drive_access(1, 0, 32'h0, 32'h0, 4'hF, 0, rdat, rerr, st, lat, got, sr);
    checks++; if (!got || lat !== 1) begin errors++; $display("FAIL w0 latency: got %0d (ready=%b) want 1", lat, got); end
    checks++; if (st !== 1) begin errors++; $display("FAIL w0 stall cycles: got %0d want 1", st); end
    checks++; if (rdat !== q || rerr !== 1'b0) begin errors++; $display("FAIL w0 data: got %h err=%b want %h err=0", rdat, rerr, q); end
    sel = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] q, rdat; bit e, got; logic rerr, sr; int st, lat;
    logic [31:0] ea [3];
    bit er [3], ew [3];
    ea[0] = 32'h13;  er[0] = 1; ew[0] = 0;
    ea[1] = 32'h200; er[1] = 0; ew[1] = 1;
    ea[2] = 32'h10;  er[2] = 1; ew[2] = 1;
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      model_access(0, er[i], ew[i], ea[i], 32'h0BADF00D, 4'hF, e, q);
      drive_access(er[i], ew[i], ea[i], 32'h0BADF00D, 4'hF, 0, rdat, rerr, st, lat, got, sr);
      checks++; if (!got || rerr !== 1'b1) begin errors++; $display("FAIL err case %0d flag: got %b (ready=%b) want 1", i, rerr, got); end
      checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL err case %0d data: got %h want 0", i, rdat); end
    end
    // Word 0 aliases index 128 and word 4 was targeted by the other two.
    for (int i = 0; i < 2; i++) begin
      logic [31:0] a;
      a = (i == 0) ? 32'h0 : 32'h10;
      model_access(0, 1, 0, a, 32'h0, 4'hF, e, q);
      drive_access(1, 0, a, 32'h0, 4'hF, 0, rdat, rerr, st, lat, got, sr);
      checks++; if (rdat !== q) begin errors++; $display("FAIL err unchanged @%h: got %h want %h", a, rdat, q); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, rdat; bit e, got; logic rerr, sr; int st, lat;
    int when [2];
    when[0] = 1; when[1] = 3;
    sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd = 1'b0; wr = 1'b1; addr = 32'h20; data = 32'h12345678; be = 4'hF;
      repeat (when[i]) @(negedge clk);
      rst = 1'b1; wr = 1'b0;
      @(negedge clk); #1;
      checks++; if (ready2 !== 1'b0 || err2 !== 1'b0 || dout2 !== 32'h0 || stall2 !== 1'b0)
        begin errors++; $display("FAIL reset mid %0d outputs: got rdy=%b err=%b data=%h stall=%b want all 0", i, ready2, err2, dout2, stall2); end
      @(negedge clk); rst = 1'b0;
      model_access(0, 1, 0, 32'h20, 32'h0, 4'hF, e, q);
      drive_access(1, 0, 32'h20, 32'h0, 4'hF, 0, rdat, rerr, st, lat, got, sr);
      checks++; if (rdat !== q || !got) begin errors++; $display("FAIL reset mid %0d read: got %h want %h", i, rdat, q); end
    end
  endtask

  task automatic test_held_inputs();
    logic [31:0] q, rdat, d; bit e, got; logic rerr, sr; int st, lat;
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      bit w;
      a = 32'($urandom_range(0, 127)) << 2;
      d = $urandom;
      w = (i % 2 == 0);
      model_access(0, !w, w, a, d, 4'hF, e, q);
      drive_access(!w, w, a, d, 4'hF, 1, rdat, rerr, st, lat, got, sr);
      checks++; if (!got || rerr !== 1'b0 || rdat !== q) begin errors++; $display("FAIL held %0d: got %h err=%b want %h err=0", i, rdat, rerr, q); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q; bit e;
    int first, second, n;
    logic [31:0] dseen [2];
    sel = 1'b0;
    model_access(0, 1, 0, 32'h10, 32'h0, 4'hF, e, q);
    rd = 1'b1; wr = 1'b0; addr = 32'h10;
    first = -1; second = -1; n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      #1;
      if (ready2) begin
        dseen[n] = dout2;
        if (n == 0) first = c; else second = c;
        n++;
      end
      @(negedge clk);
    end
    rd = 1'b0;
    @(negedge clk);
    checks++; if (n != 2 || second - first != 4) begin errors++; $display("FAIL b2b spacing: got %0d pulses gap %0d want 2 pulses gap 4", n, second - first); end
    checks++; if (n == 2 && (dseen[0] !== q || dseen[1] !== q)) begin errors++; $display("FAIL b2b data: got %h/%h want %h", dseen[0], dseen[1], q); end
  endtask

  task automatic test_random();
    logic [31:0] q, rdat, a, d; logic [3:0] b; bit e, got, r, w; logic rerr, sr; int st, lat, s;
    for (int i = 0; i < 150; i++) begin
      s = int'($urandom_range(0, 1));
      sel = s[0];
      a = 32'($urandom_range(0, 135)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      w = $urandom_range(0, 1) == 1;
      r = !w || ($urandom_range(0, 15) == 0);
      d = $urandom; b = 4'($urandom);
      model_access(s, r, w, a, d, b, e, q);
      drive_access(r, w, a, d, b, 0, rdat, rerr, st, lat, got, sr);
      checks++; if (!got || rerr !== e) begin errors++; $display("FAIL rand %0d err: got %b (ready=%b) want %b", i, rerr, got, e); end
      checks++; if (rdat !== q) begin errors++; $display("FAIL rand %0d data @%h: got %h want %h", i, a, rdat, q); end
      checks++; if (st !== exp_wait() + 1 || lat !== exp_wait() + 1) begin errors++; $display("FAIL rand %0d timing: got stall=%0d lat=%0d want %0d", i, st, lat, exp_wait() + 1); end
    end
    sel = 1'b0;
  endtask

`ifdef MEM_RESP_BYTE_EN
  task automatic test_byte_en();
    logic [31:0] q, rdat; bit e, got; logic rerr, sr; int st, lat;
    sel = 1'b0;
    model_access(0, 0, 1, 32'h40, 32'h11223344, 4'hF, e, q);
    drive_access(0, 1, 32'h40, 32'h11223344, 4'hF, 0, rdat, rerr, st, lat, got, sr);
    model_access(0, 0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, e, q);
    drive_access(0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, 0, rdat, rerr, st, lat, got, sr);
    drive_access(1, 0, 32'h40, 32'h0, 4'hF, 0, rdat, rerr, st, lat, got, sr);
    checks++; if (rdat !== 32'h11BB33DD) begin errors++; $display("FAIL be merge: got %h want 11bb33dd", rdat); end
    drive_access(0, 1, 32'h40, 32'hFFFFFFFF, 4'h0, 0, rdat, rerr, st, lat, got, sr);
    checks++; if (!got || rerr !== 1'b0) begin errors++; $display("FAIL be zero write: got err=%b ready=%b want err=0 ready=1", rerr, got); end
    drive_access(1, 0, 32'h40, 32'h0, 4'hF, 0, rdat, rerr, st, lat, got, sr);
    checks++; if (rdat !== 32'h11BB33DD) begin errors++; $display("FAIL be zero unchanged: got %h want 11bb33dd", rdat); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_zero_wait();
    test_errors();
    test_reset_mid();
    test_held_inputs();
    test_back_to_back();
`ifdef MEM_RESP_BYTE_EN
    test_byte_en();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
